ov5640_power_ctrl: RTL and testbench



---
 rtl/ov5640_pkg.sv | 23 ++
 rtl/ov5640_power_ctrl.sv | 103 ++++++++++
 tb/tb_ov5640_power_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ov5640_pkg.sv
// Shared types and constants for the OV5640 power-up sequencer.
package ov5640_pkg;

    typedef enum logic [1:0] {
        ST_PWDN = 2'd0,
        ST_RST  = 2'd1,
        ST_INIT = 2'd2,
        ST_DONE = 2'd3
    } pwr_state_e;

    localparam int CLK_FREQ_HZ         = 50_000_000;
    localparam int DEF_PWDN_CYCLES     = 250_000;
    localparam int DEF_RST_CYCLES      = 50_000;
    localparam int DEF_INIT_CYCLES     = 1_000_000;
    localparam int SIM_SHORT_DIVISOR   = 1000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ov5640_power_ctrl.sv
// OV5640 power-up sequencer: power-down, sensor reset release, init wait, done.
// Optional macro OV5640_PWR_SIM_SHORT_EN divides each phase count by 1000 (minimum 1).
module ov5640_power_ctrl
    import ov5640_pkg::*;
#(
    parameter int PWDN_CYCLES = DEF_PWDN_CYCLES,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int INIT_CYCLES = DEF_INIT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    output logic ov5640_pwdn,
    output logic ov5640_rst_n,
    output logic power_done
);

    if (PWDN_CYCLES < 1 || RST_CYCLES < 1 || INIT_CYCLES < 1) begin : g_param_check
        $error("ov5640_power_ctrl: all cycle parameters must be >= 1");
    end

`ifdef OV5640_PWR_SIM_SHORT_EN
    localparam int PWDN_LIM = (PWDN_CYCLES / SIM_SHORT_DIVISOR < 1) ? 1 : PWDN_CYCLES / SIM_SHORT_DIVISOR;
    localparam int RST_LIM  = (RST_CYCLES  / SIM_SHORT_DIVISOR < 1) ? 1 : RST_CYCLES  / SIM_SHORT_DIVISOR;
    localparam int INIT_LIM = (INIT_CYCLES / SIM_SHORT_DIVISOR < 1) ? 1 : INIT_CYCLES / SIM_SHORT_DIVISOR;
`else
    localparam int PWDN_LIM = PWDN_CYCLES;
    localparam int RST_LIM  = RST_CYCLES;
    localparam int INIT_LIM = INIT_CYCLES;
`endif

    localparam int MAX_LIM = max3(PWDN_LIM, RST_LIM, INIT_LIM);
    localparam int CNT_W   = $clog2(MAX_LIM + 1);

    // Reset holds the count at 0 and edge 0 already counts as a PWDN edge,
    // so PWDN ends one count later than the phases entered by a transition.
    localparam logic [CNT_W-1:0] PWDN_END = CNT_W'(PWDN_LIM);
    localparam logic [CNT_W-1:0] RST_END  = CNT_W'(RST_LIM - 1);
    localparam logic [CNT_W-1:0] INIT_END = CNT_W'(INIT_LIM - 1);

    pwr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pwdn_q, pwdn_d;
    logic             sensor_rst_n_q, sensor_rst_n_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            ST_PWDN: begin
                if (cnt_q == PWDN_END) begin
                    state_d = ST_RST;
                    cnt_d   = '0;
                end
            end
            ST_RST: begin
                if (cnt_q == RST_END) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            ST_INIT: begin
                if (cnt_q == INIT_END) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end
            end
            ST_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = ST_PWDN;
                cnt_d   = '0;
            end
        endcase

        // Outputs follow the next state so each pin changes on the transition edge.
        pwdn_d         = (state_d == ST_PWDN);
        sensor_rst_n_d = (state_d == ST_INIT) || (state_d == ST_DONE);
        done_d         = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_PWDN;
            cnt_q          <= '0;
            pwdn_q         <= 1'b1;
            sensor_rst_n_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pwdn_q         <= pwdn_d;
            sensor_rst_n_q <= sensor_rst_n_d;
            done_q         <= done_d;
        end
    end

    assign ov5640_pwdn  = pwdn_q;
    assign ov5640_rst_n = sensor_rst_n_q;
    assign power_done   = done_q;

endmodule

// File: tb/tb_ov5640_power_ctrl.sv
// Directed testbench for ov5640_power_ctrl; expected edges follow OV5640_PWR_SIM_SHORT_EN.
module tb_ov5640_power_ctrl;
    import ov5640_pkg::*;

    logic clk;
    logic rst_n;

    logic pwdn_a, rstn_a, done_a;
    logic pwdn_b, rstn_b, done_b;
    logic pwdn_c, rstn_c, done_c;

    logic [2:0] obs_a, obs_b, obs_c;

    int errors;
    int checks;

    ov5640_power_ctrl #(
        .PWDN_CYCLES(5),
        .RST_CYCLES (3),
        .INIT_CYCLES(4)
    ) u_dut_short (
        .clk         (clk),
        .rst_n       (rst_n),
        .ov5640_pwdn (pwdn_a),
        .ov5640_rst_n(rstn_a),
        .power_done  (done_a)
    );

    ov5640_power_ctrl #(
        .PWDN_CYCLES(1),
        .RST_CYCLES (1),
        .INIT_CYCLES(1)
    ) u_dut_min (
        .clk         (clk),
        .rst_n       (rst_n),
        .ov5640_pwdn (pwdn_b),
        .ov5640_rst_n(rstn_b),
        .power_done  (done_b)
    );

    ov5640_power_ctrl u_dut_def (
        .clk         (clk),
        .rst_n       (rst_n),
        .ov5640_pwdn (pwdn_c),
        .ov5640_rst_n(rstn_c),
        .power_done  (done_c)
    );

    assign obs_a = {pwdn_a, rstn_a, done_a};
    assign obs_b = {pwdn_b, rstn_b, done_b};
    assign obs_c = {pwdn_c, rstn_c, done_c};

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Effective phase length the sequencer should use for a given parameter.
    function automatic int eff(input int p);
`ifdef OV5640_PWR_SIM_SHORT_EN
        return (p / 1000 < 1) ? 1 : p / 1000;
`else
        return p;
`endif
    endfunction

    // Expected {pwdn, rst_n, done} after edge k given the three transition edges.
    function automatic logic [2:0] exp_out(input int k, input int e1, input int e2, input int e3);
        logic [2:0] r;
        r[2] = (k < e1);
        r[1] = (k >= e2);
        r[0] = (k >= e3);
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs_a !== 3'b100) begin
                errors++;
                $display("[TB] FAIL reset_a edge %0d: got %b expected 100", i, obs_a);
            end
            checks++;
            if (obs_b !== 3'b100) begin
                errors++;
                $display("[TB] FAIL reset_b edge %0d: got %b expected 100", i, obs_b);
            end
            checks++;
            if (obs_c !== 3'b100) begin
                errors++;
                $display("[TB] FAIL reset_c edge %0d: got %b expected 100", i, obs_c);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_short_sequence();
        int e1, e2, e3;
        logic [2:0] exp;
        e1 = eff(5);
        e2 = e1 + eff(3);
        e3 = e2 + eff(4);
        for (int k = 0; k <= e3 + 100; k++) begin
            @(posedge clk);
            #1;
            exp = exp_out(k, e1, e2, e3);
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("[TB] FAIL short_seq edge %0d: got %b expected %b", k, obs_a, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        int e1, e2, e3;
        logic [2:0] exp;
        e1 = eff(5);
        e2 = e1 + eff(3);
        e3 = e2 + eff(4);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            exp = exp_out(k, e1, e2, e3);
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("[TB] FAIL mid_pre edge %0d: got %b expected %b", k, obs_a, exp);
            end
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (obs_a !== 3'b100) begin
            errors++;
            $display("[TB] FAIL mid_reset_edge7: got %b expected 100", obs_a);
        end
        rst_n = 1'b1;
        for (int k = 0; k <= e3 + 5; k++) begin
            @(posedge clk);
            #1;
            exp = exp_out(k, e1, e2, e3);
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("[TB] FAIL mid_replay edge %0d: got %b expected %b", k, obs_a, exp);
            end
        end
    endtask

    task automatic test_reset_in_done();
        int e1, e2, e3;
        logic [2:0] exp;
        e1 = eff(5);
        e2 = e1 + eff(3);
        e3 = e2 + eff(4);
        checks++;
        if (obs_a !== 3'b011) begin
            errors++;
            $display("[TB] FAIL done_before_reset: got %b expected 011", obs_a);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (obs_a !== 3'b100) begin
            errors++;
            $display("[TB] FAIL done_reset_edge: got %b expected 100", obs_a);
        end
        rst_n = 1'b1;
        for (int k = 0; k <= e3 + 3; k++) begin
            @(posedge clk);
            #1;
            exp = exp_out(k, e1, e2, e3);
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("[TB] FAIL done_replay edge %0d: got %b expected %b", k, obs_a, exp);
            end
        end
    endtask

    task automatic test_min_params();
        logic [2:0] exp;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk);
            #1;
            exp = exp_out(k, 1, 2, 3);
            checks++;
            if (obs_b !== exp) begin
                errors++;
                $display("[TB] FAIL min_params edge %0d: got %b expected %b", k, obs_b, exp);
            end
        end
    endtask

    task automatic test_defaults();
        int e1, e2, e3, last;
        logic [2:0] exp;
        e1 = eff(250000);
        e2 = e1 + eff(50000);
        e3 = e2 + eff(1000000);
        last = (e3 + 10 < 3000) ? e3 + 10 : 3000;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk);
            #1;
            exp = exp_out(k, e1, e2, e3);
            checks++;
            if (obs_c !== exp) begin
                errors++;
                $display("[TB] FAIL defaults edge %0d: got %b expected %b", k, obs_c, exp);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        $display("[TB] starting ov5640_power_ctrl bench, clock %0d Hz nominal", CLK_FREQ_HZ);
        test_reset();
        test_short_sequence();
        test_mid_reset();
        test_reset_in_done();
        test_min_params();
        test_defaults();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
